// File: rtl/cdma_scheduler.sv
// Round-robin scheduler time-sharing one cdma gold-code spreader between NCH channels.
// Each grant loads the channel seed, spreads one data bit over CHIPS chips, then acks.
module cdma_scheduler #(
    parameter int NCH   = 4,
    parameter int CHIPS = 31,
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk_i,
    input  logic             set_i,
    input  logic [NCH-1:0]   req_i,
    input  logic [NCH-1:0]   bit_i,
    input  logic [4*NCH-1:0] seed_i,
    output logic             gen_set_no,
    output logic [3:0]       gen_seed_o,
    output logic             gen_signal_o,
    input  logic             gen_cdma_i,
    output logic             chip_o,
    output logic             chip_valid_o,
    output logic [CW-1:0]    chan_o,
    output logic [NCH-1:0]   ack_o,
    output logic             err_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0]     CNT_LAST = 8'(CHIPS - 1);
    localparam logic [NCH-1:0] ONE_HOT0 = {{(NCH-1){1'b0}}, 1'b1};

    state_t         state_r, next_s;
    logic [CW-1:0]  ptr_r, chan_r, grant_s, hi_g_s, lo_g_s, ptr_nx_s, chan_nx_s;
    logic [7:0]     cnt_r, cnt_nx_s;
    logic [3:0]     seed_r, seed_nx_s;
    logic           signal_r, signal_nx_s;
    logic           set_no_r, set_no_nx_s;
    logic           valid_r, valid_nx_s;
    logic           err_r, err_nx_s;
    logic           busy_r, busy_nx_s;
    logic [NCH-1:0] ack_r, ack_nx_s;
    logic [NCH-1:0] req_m_s;
    logic           hi_hit_s, found_s, take_s;

    // Arbitration: first requester at or after ptr, wrapping; the channel being acked is masked.
    always_comb begin
        req_m_s  = req_i;
        hi_hit_s = 1'b0;
        hi_g_s   = {CW{1'b0}};
        lo_g_s   = {CW{1'b0}};
        if (state_r == DONE) begin
            req_m_s = req_i & ~(ONE_HOT0 << chan_r);
        end else begin
            req_m_s = req_i;
        end
        for (int c = NCH - 1; c >= 0; c--) begin
            if (req_m_s[c]) begin
                lo_g_s = CW'(c);
                if (CW'(c) >= ptr_r) begin
                    hi_hit_s = 1'b1;
                    hi_g_s   = CW'(c);
                end else begin
                    hi_hit_s = hi_hit_s;
                end
            end else begin
                lo_g_s = lo_g_s;
            end
        end
        found_s = |req_m_s;
        grant_s = hi_hit_s ? hi_g_s : lo_g_s;
    end

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE:    next_s = found_s ? LOAD : IDLE;
            LOAD:    next_s = (seed_r == 4'h0) ? DONE : RUN;
            RUN:     next_s = (cnt_r == CNT_LAST) ? DONE : RUN;
            DONE:    next_s = found_s ? LOAD : IDLE;
            default: next_s = IDLE;
        endcase
    end

    // Next values of the latched grant and of every registered output.
    always_comb begin
        take_s      = found_s && ((state_r == IDLE) || (state_r == DONE));
        chan_nx_s   = take_s ? grant_s : chan_r;
        seed_nx_s   = take_s ? seed_i[{grant_s, 2'b00} +: 4] : seed_r;
        signal_nx_s = take_s ? bit_i[grant_s] : signal_r;
        cnt_nx_s    = (state_r == RUN) ? (cnt_r + 8'd1) : 8'd0;
        if (state_r == DONE) begin
            ptr_nx_s = (chan_r == CW'(NCH - 1)) ? {CW{1'b0}} : (chan_r + CW'(1));
        end else begin
            ptr_nx_s = ptr_r;
        end
        set_no_nx_s = (next_s != LOAD);
        valid_nx_s  = (next_s == RUN);
        ack_nx_s    = (next_s == DONE) ? (ONE_HOT0 << chan_r) : {NCH{1'b0}};
        // Only the LOAD->DONE path can see a zero seed; RUN is never entered with one.
        err_nx_s    = (next_s == DONE) && (seed_r == 4'h0);
        busy_nx_s   = (next_s != IDLE);
    end

    // State register.
    always_ff @(posedge clk_i or negedge set_i) begin
        if (!set_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Grant latches, pointer, chip counter and output registers; reset holds the spreader in load.
    always_ff @(posedge clk_i or negedge set_i) begin
        if (!set_i) begin
            ptr_r    <= {CW{1'b0}};
            chan_r   <= {CW{1'b0}};
            cnt_r    <= 8'd0;
            seed_r   <= 4'h0;
            signal_r <= 1'b0;
            set_no_r <= 1'b0;
            valid_r  <= 1'b0;
            ack_r    <= {NCH{1'b0}};
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            ptr_r    <= ptr_nx_s;
            chan_r   <= chan_nx_s;
            cnt_r    <= cnt_nx_s;
            seed_r   <= seed_nx_s;
            signal_r <= signal_nx_s;
            set_no_r <= set_no_nx_s;
            valid_r  <= valid_nx_s;
            ack_r    <= ack_nx_s;
            err_r    <= err_nx_s;
            busy_r   <= busy_nx_s;
        end
    end

    assign gen_set_no   = set_no_r;
    assign gen_seed_o   = seed_r;
    assign gen_signal_o = signal_r;
    assign chip_valid_o = valid_r;
    assign chip_o       = gen_cdma_i & valid_r;
    assign chan_o       = chan_r;
    assign ack_o        = ack_r;
    assign err_o        = err_r;
    assign busy_o       = busy_r;

endmodule

// File: tb/tb_cdma_scheduler.sv
// Scoreboard bench for cdma_scheduler: a transaction-level model predicts grant order,
// ack cycle and chip stream per bit; a monitor checks every ack against the queue.
module tb_cdma_scheduler;

    localparam int NCH   = 4;
    localparam int CHIPS = 31;

    logic        clk_i = 1'b0;
    logic        set_i;
    logic [3:0]  req_i, bit_i;
    logic [15:0] seed_i;
    logic        gen_set_no, gen_signal_o, gen_cdma_i, chip_o, chip_valid_o, err_o, busy_o;
    logic [3:0]  gen_seed_o, ack_o;
    logic [1:0]  chan_o;

    cdma_scheduler #(.NCH(NCH), .CHIPS(CHIPS)) dut (
        .clk_i(clk_i), .set_i(set_i), .req_i(req_i), .bit_i(bit_i), .seed_i(seed_i),
        .gen_set_no(gen_set_no), .gen_seed_o(gen_seed_o), .gen_signal_o(gen_signal_o),
        .gen_cdma_i(gen_cdma_i), .chip_o(chip_o), .chip_valid_o(chip_valid_o),
        .chan_o(chan_o), .ack_o(ack_o), .err_o(err_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Stand-in spreader: holds the seed while set is low, shifts two 5-bit LFSRs otherwise.
    logic [4:0] lf1 = 5'd0, lf2 = 5'd0;
    always @(posedge clk_i) begin
        if (!gen_set_no) begin
            lf1 <= {1'b1, gen_seed_o};
            lf2 <= {1'b1, gen_seed_o};
        end else begin
            lf1 <= {lf1[3:0], lf1[4] ^ lf1[2]};
            lf2 <= {lf2[3:0], lf2[4] ^ lf2[3] ^ lf2[2] ^ lf2[1]};
        end
    end
    assign gen_cdma_i = lf1[4] ^ lf2[4] ^ gen_signal_o;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int               ch;
        logic             err;
        int               cyc;
        int               n;
        logic [CHIPS-1:0] chips;
    } exp_t;
    exp_t exp_q[$];

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int mptr     = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tot_cnt++;
        if (act !== expv) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        else pass_cnt++;
    endtask

    // Gold chip sequence for a seed, computed bit by bit with integer arithmetic.
    function automatic logic [CHIPS-1:0] gold(input logic [3:0] sd, input logic b);
        int s1, s2;
        logic [CHIPS-1:0] r;
        s1 = 16 + int'(sd);
        s2 = 16 + int'(sd);
        r  = '0;
        for (int i = 0; i < CHIPS; i++) begin
            r[i] = logic'((((s1 >> 4) & 1) + ((s2 >> 4) & 1) + int'(b)) % 2);
            s1 = (s1 % 16) * 2 + (((s1 >> 4) & 1) + ((s1 >> 2) & 1)) % 2;
            s2 = (s2 % 16) * 2 + (((s2 >> 4) & 1) + ((s2 >> 3) & 1) + ((s2 >> 2) & 1) + ((s2 >> 1) & 1)) % 2;
        end
        return r;
    endfunction

    // Predict the acks of one burst of requests issued while idle at cycle start.
    task automatic model_round(input logic [3:0] mask, input logic [3:0] bits, input logic [15:0] seeds,
                               input int nacks, input bit reassert, input int start);
        logic [3:0] pend;
        int t, g;
        exp_t e;
        pend = mask;
        t    = start;
        for (int a = 0; a < nacks; a++) begin
            g = -1;
            for (int i = 0; i < NCH; i++)
                if (g < 0 && pend[(mptr + i) % NCH]) g = (mptr + i) % NCH;
            e.ch  = g;
            e.err = (seeds[4*g +: 4] == 4'h0);
            t     = t + (e.err ? 2 : CHIPS + 2);
            e.cyc = t;
            e.n   = e.err ? 0 : CHIPS;
            e.chips = e.err ? '0 : gold(seeds[4*g +: 4], bits[g]);
            exp_q.push_back(e);
            if (!reassert) pend[g] = 1'b0;
            mptr = (g + 1) % NCH;
        end
    endtask

    task automatic issue(input logic [3:0] mask, input logic [3:0] bits, input logic [15:0] seeds,
                         input int nacks, input bit reassert);
        @(negedge clk_i);
        chk("idle_before_grant", busy_o, 0);
        req_i  = mask;
        bit_i  = bits;
        seed_i = seeds;
        model_round(mask, bits, seeds, nacks, reassert, cyc);
    endtask

    task automatic wait_acks(input int n, input bit reassert);
        int got_n, budget;
        got_n  = 0;
        budget = n * 40 + 20;
        while (got_n < n && budget > 0) begin
            @(negedge clk_i);
            budget--;
            if (ack_o != 4'b0) begin
                got_n++;
                if (!reassert || got_n >= n) req_i = req_i & ~ack_o;
                if (reassert && got_n >= n) req_i = 4'b0;
            end
        end
        chk("ack_wait", got_n, n);
    endtask

    task automatic wait_chips(input int k);
        int seen, budget;
        seen   = 0;
        budget = 100;
        while (seen < k && budget > 0) begin
            @(negedge clk_i);
            budget--;
            if (chip_valid_o) seen++;
        end
        chk("chip_wait", seen, k);
    endtask

    // Monitor: collects chips and checks each ack against the scoreboard head.
    logic [CHIPS-1:0] got = '0;
    int nch = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!set_i) begin
                nch = 0;
                got = '0;
            end else begin
                if (chip_valid_o) begin
                    if (nch < CHIPS) got[nch] = chip_o;
                    nch++;
                end
                if (ack_o != 4'b0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", ack_o, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_onehot", ack_o, 64'd1 << e.ch);
                        chk("err", err_o, e.err);
                        chk("chan", chan_o, e.ch);
                        chk("ack_cycle", cyc, e.cyc);
                        chk("chip_count", nch, e.n);
                        chk("chips", got, e.chips);
                    end
                    nch = 0;
                    got = '0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  m, b;
        logic [15:0] s;
        set_i = 1'b0; req_i = 4'b0; bit_i = 4'b0; seed_i = 16'h0;
        repeat (3) @(negedge clk_i);
        chk("rst_set_no", gen_set_no, 0);
        chk("rst_chan", chan_o, 0);
        chk("rst_seed", gen_seed_o, 0);
        chk("rst_signal", gen_signal_o, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_valid", chip_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        set_i = 1'b1;
        @(negedge clk_i);
        chk("post_rst_set_no", gen_set_no, 1);

        // Fairness: all four held, re-requesting after each ack.
        issue(4'hF, 4'b0101, 16'h7531, 5, 1'b1);
        wait_acks(5, 1'b1);
        // Single channel, then the same with inverted data.
        issue(4'h1, 4'h0, 16'h0001, 1, 1'b0);
        wait_acks(1, 1'b0);
        issue(4'h1, 4'h1, 16'h0001, 1, 1'b0);
        wait_acks(1, 1'b0);
        // Zero seed on channel 2.
        issue(4'h4, 4'h0, 16'h0000, 1, 1'b0);
        wait_acks(1, 1'b0);
        // Mid-bit request drop and data/seed changes on channel 1.
        issue(4'h2, 4'h0, 16'h0050, 1, 1'b0);
        wait_chips(10);
        req_i[1]    = 1'b0;
        bit_i[1]    = 1'b1;
        seed_i[7:4] = 4'hA;
        wait_acks(1, 1'b0);

        repeat (20) begin
            m = 4'($urandom_range(1, 15));
            b = 4'($urandom);
            for (int k = 0; k < NCH; k++)
                s[4*k +: 4] = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            issue(m, b, s, $countones(m), 1'b0);
            wait_acks($countones(m), 1'b0);
        end

        // Reset in the middle of a bit, with the pointer left at 1.
        issue(4'h1, 4'h1, 16'h0003, 1, 1'b0);
        wait_acks(1, 1'b0);
        issue(4'h4, 4'h0, 16'h0900, 1, 1'b0);
        wait_chips(16);
        set_i = 1'b0;
        req_i = 4'b0;
        exp_q.delete();
        mptr  = 0;
        #1;
        chk("midrst_valid", chip_valid_o, 0);
        chk("midrst_set_no", gen_set_no, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_ack", ack_o, 0);
        repeat (3) @(negedge clk_i);
        set_i = 1'b1;
        issue(4'h3, 4'h3, 16'h00C6, 2, 1'b0);
        wait_acks(2, 1'b0);
        @(negedge clk_i);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/cdma_scheduler.md
# cdma_scheduler

Round-robin scheduler that time-shares one `cdma` gold-code spreader between NCH transmit channels. Each granted request spreads one data bit over CHIPS chips. For every bit the scheduler:
- loads the channel's 4-bit seed into the spreader by pulsing its active-low `set_i`;
- drives the data bit onto the spreader's `signal_i`;
- qualifies the returned chips;
- acknowledges the requester.

It sits between the per-channel framers and the single `cdma` instance.

## Interface
Parameters:
- `NCH`, 4, number of requesting channels (2..8).
- `CHIPS`, 31, chips per data bit, equal to the gold sequence length (1..255).

Ports:
- `clk_i`  in  1  clock; also clocks the `cdma` instance.
- `set_i`  in  1  reset, asynchronous, active-low.
- `req_i`  in  NCH  per-channel bit request; level, held until `ack_o`.
- `bit_i`  in  NCH  per-channel data bit; sampled at grant.
- `seed_i`  in  4*NCH  per-channel seed; channel k is at [4k+3:4k]; sampled at grant.
- `gen_set_no`  out  1  to `cdma.set_i`; low loads the seed.
- `gen_seed_o`  out  4  to `cdma.seed_i`.
- `gen_signal_o`  out  1  to `cdma.signal_i`.
- `gen_cdma_i`  in  1  from `cdma.cdma_o`.
- `chip_o`  out  1  spread chip; equals `gen_cdma_i & chip_valid_o`.
- `chip_valid_o`  out  1  high while `chip_o` carries a chip.
- `chan_o`  out  clog2(NCH)  channel currently granted.
- `ack_o`  out  NCH  one-hot, one-cycle pulse on bit completion.
- `err_o`  out  1  one-cycle pulse together with `ack_o` when the grant was rejected.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- Round-robin pointer `ptr`, reset value 0.
  - Arbitration picks the first requesting channel at or after `ptr`, wrapping modulo NCH.
  - After each DONE, `ptr` becomes grant+1 (mod NCH).
- IDLE:
  - If no request is pending, stay in IDLE.
  - If any `req_i` bit is set, latch grant, `bit_i[grant]` and `seed_i[grant]` into `chan_o`, `gen_signal_o` and `gen_seed_o`, then go to LOAD.
- LOAD (1 cycle):
  - `gen_set_no` = 0 and the chip counter clears to 0.
  - If the latched seed is 4'h0, go to DONE with error; an all-zero seed locks up both LFSRs.
  - Otherwise go to RUN.
- RUN (CHIPS cycles):
  - `gen_set_no` = 1 and `chip_valid_o` = 1.
  - The counter increments each cycle.
  - In the cycle with counter = CHIPS-1, go to DONE.
- DONE (1 cycle):
  - `ack_o[chan_o]` = 1, and `err_o` = 1 if the grant was rejected.
  - Arbitration runs with the acked channel's request masked off.
  - If a winner exists, latch it and go directly to LOAD; otherwise go to IDLE.
- Latched `bit`/`seed` values are frozen from grant until the next grant. Changes on `bit_i`/`seed_i` mid-bit have no effect.
- If `req_i[k]` drops mid-bit, the bit still runs to completion and `ack_o[k]` still pulses.
- A request that arrives during RUN waits until the next arbitration point.
- Reset (asynchronous, any state) forces:
  - state = IDLE, `ptr` = 0, counter = 0;
  - `chan_o` = 0, `gen_seed_o` = 0, `gen_signal_o` = 0;
  - `gen_set_no` = 0, which holds the spreader in load;
  - `ack_o` = 0, `err_o` = 0, `chip_valid_o` = 0, `busy_o` = 0.
- The first cycle after reset deasserts returns `gen_set_no` to 1 in IDLE.

## Timing
- All outputs are registered except `chip_o`, which is combinational from `gen_cdma_i`.
- Grant latency: `req_i` high in IDLE at edge n, then LOAD during cycle n+1.
- First chip appears in the cycle after LOAD. It is computed from the seed state, because `cdma` holds the seed while `gen_set_no` is low and shifts on the first edge after release.
- Per-bit occupancy: 1 (LOAD) + CHIPS (RUN) + 1 (DONE) = CHIPS+2 cycles, back-to-back with no idle gap.
- From an idle start, add 1 arbitration cycle.
- Rejected seed: grant, LOAD, DONE; `ack_o`+`err_o` arrive 2 cycles after grant and `chip_valid_o` never rises.
- The `chan_o` change and the new LOAD occur in the cycle after DONE.
- Simultaneous requests are resolved purely by `ptr`, with no fixed priority.

## Test plan
- Single channel:
  - Stimulus: NCH=4, CHIPS=31; `req_i`=4'b0001, `bit_i[0]`=0, seed 4'h1.
  - Required: exactly 31 `chip_valid_o` cycles, `chip_o` equal to the gold sequence of seed 1 (first chip 0), then `ack_o`=4'b0001 for 1 cycle. Total 34 cycles from req to ack pulse end.
- Data inversion:
  - Stimulus: same as the single-channel case with `bit_i[0]`=1.
  - Required: all 31 chips are the bitwise inverse of the `bit_i`=0 run.
- Round-robin fairness:
  - Stimulus: `req_i`=4'b1111 held high, re-asserted after each ack.
  - Required: grant order 0,1,2,3,0; each ack is 33 cycles after the previous one; no gap cycle.
- Zero seed:
  - Stimulus: channel 2 seed 4'h0, `req_i`=4'b0100.
  - Required: `ack_o`=4'b0100 with `err_o`=1, `chip_valid_o` never high, then IDLE.
- Mid-bit changes:
  - Stimulus: during RUN at chip 10, drop `req_i[1]` and toggle `bit_i[1]` and `seed_i[1]`.
  - Required: chips continue unchanged through chip 30, and `ack_o[1]` still pulses.
- Reset mid-operation:
  - Stimulus: assert `set_i`=0 at chip 15.
  - Required: immediately `chip_valid_o`=0, `gen_set_no`=0, `busy_o`=0, no `ack_o`.
  - After release with `req_i`=4'b0011, channel 0 is granted first (`ptr`=0).
